// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: walks every input vector of an N_IN-input combinational
// block in ascending order, holds each vector for SETTLE_CYC cycles, samples
// the block's output into a truth table and compares it with a latched
// expected table.
module truth_table_sweeper #(
    parameter int N_IN       = 3,
    parameter int SETTLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   expected,
    input  logic                 func_in,
    output logic [N_IN-1:0]      vec_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   table_out,
    output logic                 mismatch,
    output logic [N_IN:0]        mismatch_cnt,
    output logic [N_IN-1:0]      first_fail
);

    localparam int TBL_W = 2**N_IN;
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};
    localparam logic [N_IN-1:0]  VEC_ONE  = N_IN'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [TBL_W-1:0]   exp_lat;

    // The mismatch counter is wide enough for every vector to fail, so a
    // plain increment never wraps.
    function automatic logic [N_IN:0] bump_count(input logic [N_IN:0] value);
        return value + (N_IN+1)'(1);
    endfunction

    // Sequencer: start/abort handling, settle timing, capture and compare.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            exp_lat      <= '0;
            vec_out      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            table_out    <= '0;
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
        end else begin
            // done is a single-cycle pulse; only the final capture raises it.
            done <= 1'b0;

            if (abort && (state == S_SETTLE || state == S_CAPTURE)) begin
                // Partial table and mismatch results are kept for inspection.
                state   <= S_IDLE;
                vec_out <= '0;
                cnt     <= '0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        // abort outranks a simultaneous start.
                        if (start && !abort) begin
                            exp_lat      <= expected;
                            table_out    <= '0;
                            mismatch     <= 1'b0;
                            mismatch_cnt <= '0;
                            first_fail   <= '0;
                            vec_out      <= '0;
                            cnt          <= '0;
                            busy         <= 1'b1;
                            state        <= S_SETTLE;
                        end
                    end

                    S_SETTLE: begin
                        if (cnt == CNT_LAST) begin
                            state <= S_CAPTURE;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end

                    S_CAPTURE: begin
                        table_out[vec_out] <= func_in;
                        if (func_in != exp_lat[vec_out]) begin
                            mismatch_cnt <= bump_count(mismatch_cnt);
                            mismatch     <= 1'b1;
                            // mismatch is still low only on the first failure.
                            if (!mismatch) begin
                                first_fail <= vec_out;
                            end
                        end
                        if (vec_out == VEC_LAST) begin
                            // Last vector stays on the pins after the sweep.
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            // vec_out only moves here, so it is stable for
                            // the whole settle window plus the capture cycle.
                            vec_out <= vec_out + VEC_ONE;
                            cnt     <= '0;
                            state   <= S_SETTLE;
                        end
                    end

                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
